// File: rtl/sc_input_debounce2_if.sv
// Raw and conditioned signal bundle between the board inputs and the NOR gate stage.
// The master drives the raw inputs; the slave (the debouncer) drives the clean levels and pulses.
interface sc_input_debounce2_if;
  logic SC_InputDebounce2_a_InRaw;
  logic SC_InputDebounce2_b_InRaw;
  logic SC_InputDebounce2_a_Out;
  logic SC_InputDebounce2_b_Out;
  logic SC_InputDebounce2_aChange_Out;
  logic SC_InputDebounce2_bChange_Out;

  modport master (
    output SC_InputDebounce2_a_InRaw,
    output SC_InputDebounce2_b_InRaw,
    input  SC_InputDebounce2_a_Out,
    input  SC_InputDebounce2_b_Out,
    input  SC_InputDebounce2_aChange_Out,
    input  SC_InputDebounce2_bChange_Out
  );

  modport slave (
    input  SC_InputDebounce2_a_InRaw,
    input  SC_InputDebounce2_b_InRaw,
    output SC_InputDebounce2_a_Out,
    output SC_InputDebounce2_b_Out,
    output SC_InputDebounce2_aChange_Out,
    output SC_InputDebounce2_bChange_Out
  );
endinterface

// File: rtl/sc_input_debounce2.sv
// Two-channel synchronizer + debouncer feeding the NOR gate stage.
// Each channel: two-flop synchronizer, STABLE/COUNTING FSM, registered level and change pulse.
module sc_input_debounce2 #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_WIDTH       = 18
) (
  input logic                 SC_InputDebounce2_CLOCK_50,
  input logic                 SC_InputDebounce2_RESET_InLow,
  sc_input_debounce2_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic {STABLE, COUNTING} state_t;

  logic [1:0] rawIn;
  assign rawIn = {bus.SC_InputDebounce2_b_InRaw, bus.SC_InputDebounce2_a_InRaw};

  for (genvar ch = 0; ch < 2; ch++) begin : gChan
    logic                 sync1;
    logic                 sync2;
    logic                 outQ;
    logic                 changeQ;
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    // Only sync2 feeds the FSM; sync1 may go metastable.
    always_ff @(posedge SC_InputDebounce2_CLOCK_50 or negedge SC_InputDebounce2_RESET_InLow) begin
      if (!SC_InputDebounce2_RESET_InLow) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        outQ    <= 1'b0;
        changeQ <= 1'b0;
        state   <= STABLE;
        cnt     <= '0;
      end else begin
        sync1   <= rawIn[ch];
        sync2   <= sync1;
        changeQ <= 1'b0;
        case (state)
          STABLE: begin
            cnt <= '0;
            if (sync2 != outQ) begin
              if (DEBOUNCE_CYCLES == 1) begin
                outQ    <= sync2;
                changeQ <= 1'b1;
              end else begin
                state <= COUNTING;
                cnt   <= CNT_ONE;
              end
            end
          end
          COUNTING: begin
            if (sync2 == outQ) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              outQ    <= sync2;
              changeQ <= 1'b1;
              cnt     <= '0;
              state   <= STABLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.SC_InputDebounce2_a_Out       = gChan[0].outQ;
  assign bus.SC_InputDebounce2_b_Out       = gChan[1].outQ;
  assign bus.SC_InputDebounce2_aChange_Out = gChan[0].changeQ;
  assign bus.SC_InputDebounce2_bChange_Out = gChan[1].changeQ;
endmodule

// File: tb/tb_sc_input_debounce2.sv
// Bench for sc_input_debounce2 (DEBOUNCE_CYCLES=4): run-length reference model checked
// every cycle, directed scenarios with literal expectations, then randomized bouncing.
module tb_sc_input_debounce2;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic clk;
  logic rstN;
  logic aRaw;
  logic bRaw;
  logic aOut;
  logic bOut;
  logic aChg;
  logic bChg;

  sc_input_debounce2_if dbIf();

  assign dbIf.SC_InputDebounce2_a_InRaw = aRaw;
  assign dbIf.SC_InputDebounce2_b_InRaw = bRaw;
  assign aOut = dbIf.SC_InputDebounce2_a_Out;
  assign bOut = dbIf.SC_InputDebounce2_b_Out;
  assign aChg = dbIf.SC_InputDebounce2_aChange_Out;
  assign bChg = dbIf.SC_InputDebounce2_bChange_Out;

  sc_input_debounce2 #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (CW)
  ) dut (
    .SC_InputDebounce2_CLOCK_50   (clk),
    .SC_InputDebounce2_RESET_InLow(rstN),
    .bus                          (dbIf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference: a level must disagree with out on D consecutive edges, seen two edges late.
  logic mD1[2];
  logic mD2[2];
  logic mOut[2];
  logic mChg[2];
  int   mRun[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      mD1[c] = 0; mD2[c] = 0; mOut[c] = 0; mChg[c] = 0; mRun[c] = 0;
    end
    forever begin
      @(posedge clk or negedge rstN);
      for (int c = 0; c < 2; c++) begin
        if (!rstN) begin
          mD1[c] = 0; mD2[c] = 0; mOut[c] = 0; mChg[c] = 0; mRun[c] = 0;
        end else begin
          logic s;
          s      = mD2[c];
          mD2[c] = mD1[c];
          mD1[c] = (c == 0) ? aRaw : bRaw;
          mChg[c] = 0;
          mRun[c] = (s != mOut[c]) ? mRun[c] + 1 : 0;
          if (mRun[c] == int'(D)) begin
            mOut[c] = s;
            mChg[c] = 1;
            mRun[c] = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        chk("model_aOut", aOut, mOut[0]);
        chk("model_bOut", bOut, mOut[1]);
        chk("model_aChg", aChg, mChg[0]);
        chk("model_bChg", bChg, mChg[1]);
      end
    end
  end

  int nA;
  int nB;
  int holdA;
  int holdB;

  initial begin
    aRaw = 0; bRaw = 0; rstN = 1;
    #1 rstN = 0;
    checkEn = 1'b1;

    // Reset held 3 cycles, then quiet for 20 cycles
    repeat (3) @(negedge clk);
    #2 rstN = 1;
    nA = 0; nB = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aChg) nA++;
      if (bChg) nB++;
    end
    chk("rst_aOut", aOut, 1'b0);
    chk("rst_bOut", bOut, 1'b0);
    chk("rst_no_pulses", 1'(nA + nB != 0), 1'b0);

    // Single rise on a: out at E0+5, one pulse, b untouched
    @(negedge clk) aRaw = 1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 chk("rise_a_E4", aOut, 1'b0);
    @(posedge clk);
    #1 chk("rise_a_E5", aOut, 1'b1);
    chk("rise_aChg_E5", aChg, 1'b1);
    chk("rise_b_quiet", bOut, 1'b0);
    chk("rise_bChg_quiet", bChg, 1'b0);
    @(posedge clk);
    #1 chk("rise_aChg_E6", aChg, 1'b0);
    @(negedge clk) aRaw = 0;
    repeat (12) @(negedge clk);

    // 3-cycle glitch rejected, 4-cycle pulse accepted twice
    nA = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aChg) nA++;
      aRaw = (i < 3);
    end
    chk("glitch3_no_pulse", 1'(nA != 0), 1'b0);
    chk("glitch3_aOut", aOut, 1'b0);
    nA = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aChg) nA++;
      aRaw = (i < 4);
    end
    chk("pulse4_two_pulses", 1'(nA == 2), 1'b1);
    chk("pulse4_aOut_back", aOut, 1'b0);

    // Simultaneous rise on a and b
    @(negedge clk) begin aRaw = 1; bRaw = 1; end
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 chk("both_nor_before", ~(aOut | bOut), 1'b1);
    @(posedge clk);
    #1 chk("both_aOut", aOut, 1'b1);
    chk("both_bOut", bOut, 1'b1);
    chk("both_aChg", aChg, 1'b1);
    chk("both_bChg", bChg, 1'b1);
    chk("both_nor_after", ~(aOut | bOut), 1'b0);
    @(negedge clk) begin aRaw = 0; bRaw = 0; end
    repeat (12) @(negedge clk);

    // Reset after two COUNTING cycles; restart needs full latency from first edge after release
    @(negedge clk) aRaw = 1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rstN = 0;
    #1 chk("midrst_aOut", aOut, 1'b0);
    chk("midrst_aChg", aChg, 1'b0);
    @(negedge clk);
    #2 rstN = 1;
    repeat (5) @(posedge clk);
    #1 chk("midrst_E4", aOut, 1'b0);
    @(posedge clk);
    #1 chk("midrst_E5_aOut", aOut, 1'b1);
    chk("midrst_E5_aChg", aChg, 1'b1);
    @(negedge clk) aRaw = 0;
    repeat (12) @(negedge clk);

    // Toggle every 2 cycles, then hold high: exactly one pulse
    nA = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (aChg) nA++;
      aRaw = (i >= 18) ? 1'b1 : 1'((i / 2) % 2);
    end
    chk("toggle_one_pulse", 1'(nA == 1), 1'b1);
    chk("toggle_aOut_high", aOut, 1'b1);

    // Randomized bouncing with occasional asynchronous resets
    holdA = 0; holdB = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (holdA == 0) begin aRaw = ~aRaw; holdA = $urandom_range(1, 8); end else holdA--;
      if (holdB == 0) begin bRaw = ~bRaw; holdB = $urandom_range(1, 8); end else holdB--;
      if ($urandom_range(0, 399) == 0) begin
        #2 rstN = 0;
        #4 rstN = 1;
      end
    end

    repeat (2) @(negedge clk);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
